// File: rtl/cp0_int_sched_if.sv
// Signal bundle between the interrupt scheduler and its surroundings (device bus, hazard unit, CP0).
// master = environment side, slave = scheduler side.
interface cp0_int_sched_if;
   logic [5:0]  hw_irq;
   logic [5:0]  irq_clr;
   logic [5:0]  im;
   logic        ie;
   logic        exl;
   logic        exc_valid;
   logic [4:0]  exc_code;
   logic        eret;
   logic        pipe_stall;
   logic [5:0]  hwint_o;
   logic [4:0]  exc_code_o;
   logic        int_take;
   logic        flush;
   logic        pc_redirect;
   logic [31:0] redirect_pc;
   logic        busy;

   modport master (
      output hw_irq, irq_clr, im, ie, exl, exc_valid, exc_code, eret, pipe_stall,
      input  hwint_o, exc_code_o, int_take, flush, pc_redirect, redirect_pc, busy
   );

   modport slave (
      input  hw_irq, irq_clr, im, ie, exl, exc_valid, exc_code, eret, pipe_stall,
      output hwint_o, exc_code_o, int_take, flush, pc_redirect, redirect_pc, busy
   );
endinterface

// File: rtl/cp0_int_sched.sv
// Interrupt/exception scheduler in front of CP0: pending latch, entry arbitration, flush/redirect sequencing.
// Define CP0_INT_EDGE_EN for edge-triggered interrupt sources (default: level-triggered).
module cp0_int_sched #(
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input logic       clk,
   input logic       reset,
   cp0_int_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT, SERVICE} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [5:0] pend;
   logic       take_exc, take_irq;
   logic       int_take_r;
   logic [4:0] exc_code_r;

`ifdef CP0_INT_EDGE_EN
   logic [5:0] hw_irq_p0;

   // Rising edge sets, device ack clears; a coincident set wins over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hw_irq_p0 <= '0;
         pend      <= '0;
      end else begin
         hw_irq_p0 <= bus.hw_irq;
         pend      <= (pend & ~bus.irq_clr) | (bus.hw_irq & ~hw_irq_p0);
      end
   end
`else
   logic unused_irq_clr;
   assign unused_irq_clr = ^bus.irq_clr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pend <= '0;
      else       pend <= bus.hw_irq;
   end
`endif

   // State register plus the registered entry outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         int_take_r <= 1'b0;
         exc_code_r <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         int_take_r <= take_exc | take_irq;
         if (take_exc)      exc_code_r <= bus.exc_code;
         else if (take_irq) exc_code_r <= 5'd0;
      end
   end

   // Next-state: entry arbitration only happens in IDLE; exceptions beat interrupts
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      take_exc  = 1'b0;
      take_irq  = 1'b0;
      case (state)
         IDLE: begin
            take_exc = !bus.pipe_stall && !bus.exl && bus.exc_valid;
            take_irq = !bus.pipe_stall && !bus.exl && !bus.exc_valid && bus.ie && (|(pend & bus.im));
            if (take_exc || take_irq) begin
               state_nxt = FLUSH;
               cnt_nxt   = CNT_LOAD;
            end
         end
         FLUSH: begin
            if (cnt == 4'd0) state_nxt = REDIRECT;
            else             cnt_nxt   = cnt - 4'd1;
         end
         REDIRECT: state_nxt = SERVICE;
         SERVICE: begin
            if (bus.eret) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.flush       = (state == FLUSH) || (state == REDIRECT);
      bus.pc_redirect = (state == REDIRECT);
      bus.busy        = (state != IDLE);
   end

   assign bus.hwint_o     = pend;
   assign bus.exc_code_o  = exc_code_r;
   assign bus.int_take    = int_take_r;
   assign bus.redirect_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_int_sched.sv
// Directed bench for cp0_int_sched: expected entry codes are queued at stimulus time and popped on int_take.
module tb_cp0_int_sched;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   passes = 0;
   int   fails  = 0;
   logic [4:0] sb_q[$];

`ifdef CP0_INT_EDGE_EN
   localparam bit EDGE = 1'b1;
`else
   localparam bit EDGE = 1'b0;
`endif

   cp0_int_sched_if bus ();

   cp0_int_sched dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits for int_take (bounded), then checks latency, code and the flush/redirect sequence.
   task automatic entry_seq(input string tag, input int lat_exp);
      int n = 0;
      logic [4:0] exp_code;
      while (bus.int_take !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      exp_code = (sb_q.size() > 0) ? sb_q.pop_front() : 5'h1f;
      chk({tag, "_lat"}, n, lat_exp);
      chk({tag, "_code"}, bus.exc_code_o, exp_code);
      chk({tag, "_flush1"}, bus.flush, 1'b1);
      chk({tag, "_busy"}, bus.busy, 1'b1);
      step();
      chk({tag, "_take_pulse"}, bus.int_take, 1'b0);
      chk({tag, "_flush2"}, bus.flush, 1'b1);
      chk({tag, "_noredir"}, bus.pc_redirect, 1'b0);
      step();
      chk({tag, "_redir"}, bus.pc_redirect, 1'b1);
      chk({tag, "_redir_flush"}, bus.flush, 1'b1);
      chk({tag, "_redir_pc"}, bus.redirect_pc, 32'h0000_4180);
      step();
      chk({tag, "_svc_flush"}, bus.flush, 1'b0);
      chk({tag, "_svc_redir"}, bus.pc_redirect, 1'b0);
      chk({tag, "_svc_busy"}, bus.busy, 1'b1);
   endtask

   task automatic do_eret(input string tag);
      bus.eret = 1'b1;
      step();
      bus.eret = 1'b0;
      chk({tag, "_eret_idle"}, bus.busy, 1'b0);
   endtask

   initial begin
      reset          = 1'b1;
      bus.hw_irq     = '0;
      bus.irq_clr    = '0;
      bus.im         = '0;
      bus.ie         = 1'b0;
      bus.exl        = 1'b0;
      bus.exc_valid  = 1'b0;
      bus.exc_code   = '0;
      bus.eret       = 1'b0;
      bus.pipe_stall = 1'b0;
      step();
      step();
      chk("rst_hwint", bus.hwint_o, 6'd0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_take", bus.int_take, 1'b0);
      chk("rst_flush", bus.flush, 1'b0);
      chk("rst_redir", bus.pc_redirect, 1'b0);
      chk("rst_code", bus.exc_code_o, 5'd0);
      chk("rst_pc", bus.redirect_pc, 32'h0000_4180);
      reset = 1'b0;
      step();

      // Basic interrupt entry from a one-cycle pulse on hw_irq[0]
      bus.im = 6'b000001;
      bus.ie = 1'b1;
      bus.hw_irq = 6'b000001;
      sb_q.push_back(5'd0);
      step();
      bus.hw_irq = '0;
      chk("irq_pend", bus.hwint_o, 6'b000001);
      chk("irq_not_yet", bus.int_take, 1'b0);
      entry_seq("irq", 1);
      bus.irq_clr = 6'b000001;
      step();
      bus.irq_clr = '0;
      step();
      chk("irq_still_busy", bus.busy, 1'b1);
      do_eret("irq");
      step();
      chk("irq_no_retake", bus.int_take, 1'b0);

      // Exception and unmasked interrupt in the same cycle: exception first, irq after eret
      bus.hw_irq = 6'b000001;
      step();
      bus.exc_valid = 1'b1;
      bus.exc_code  = 5'd10;
      sb_q.push_back(5'd10);
      sb_q.push_back(5'd0);
      entry_seq("exc_prio", 1);
      bus.exc_valid = 1'b0;
      do_eret("exc_prio");
      entry_seq("irq_after", 1);
      bus.hw_irq  = '0;
      bus.irq_clr = 6'b000001;
      step();
      bus.irq_clr = '0;
      do_eret("irq_after");
      step();
      chk("irq_after_clear", bus.hwint_o, 6'd0);

      // Stall holds off an exception entry
      bus.pipe_stall = 1'b1;
      bus.exc_valid  = 1'b1;
      bus.exc_code   = 5'd4;
      sb_q.push_back(5'd4);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_no_take", bus.int_take, 1'b0);
         chk("stall_idle", bus.busy, 1'b0);
      end
      bus.pipe_stall = 1'b0;
      entry_seq("stall", 1);
      bus.exc_valid = 1'b0;
      do_eret("stall");
      step();
      chk("code_hold", bus.exc_code_o, 5'd4);

      // Pending behaviour: long-held line with a mid-way clear, then coincident set/clear
      bus.im = '0;
      bus.hw_irq = 6'b001000;
      step();
      chk("pend_set", bus.hwint_o, 6'b001000);
      for (int i = 0; i < 3; i++) step();
      bus.irq_clr = 6'b001000;
      step();
      bus.irq_clr = '0;
      chk("pend_clr", bus.hwint_o, EDGE ? 6'd0 : 6'b001000);
      for (int i = 0; i < 15; i++) step();
      chk("pend_no_reset", bus.hwint_o, EDGE ? 6'd0 : 6'b001000);
      bus.hw_irq = '0;
      step();
      bus.hw_irq  = 6'b001000;
      bus.irq_clr = 6'b001000;
      step();
      bus.irq_clr = '0;
      chk("pend_set_wins", bus.hwint_o, 6'b001000);
      bus.hw_irq  = '0;
      bus.irq_clr = 6'b001000;
      step();
      bus.irq_clr = '0;
      step();
      chk("pend_cleared", bus.hwint_o, 6'd0);

      // Masking: im, ie and exl each block entry; eret in IDLE does nothing
      bus.hw_irq = 6'b000010;
      bus.im = 6'b000001;
      bus.ie = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("mask_pend", bus.hwint_o, 6'b000010);
      chk("mask_im", bus.int_take, 1'b0);
      chk("mask_im_busy", bus.busy, 1'b0);
      bus.im = 6'b000010;
      bus.ie = 1'b0;
      for (int i = 0; i < 3; i++) step();
      chk("mask_ie", bus.int_take, 1'b0);
      bus.ie  = 1'b1;
      bus.exl = 1'b1;
      for (int i = 0; i < 3; i++) step();
      chk("mask_exl", bus.int_take, 1'b0);
      chk("mask_exl_busy", bus.busy, 1'b0);
      bus.eret = 1'b1;
      step();
      bus.eret = 1'b0;
      chk("idle_eret_busy", bus.busy, 1'b0);
      chk("idle_eret_take", bus.int_take, 1'b0);
      bus.exl = 1'b0;
      sb_q.push_back(5'd0);
      entry_seq("unmask", 1);
      bus.hw_irq  = '0;
      bus.irq_clr = 6'b000010;
      step();
      bus.irq_clr = '0;
      do_eret("unmask");

      // Asynchronous reset in the middle of FLUSH
      bus.im = '0;
      bus.hw_irq = 6'b000100;
      step();
      bus.exc_valid = 1'b1;
      bus.exc_code  = 5'd12;
      step();
      chk("mid_take", bus.int_take, 1'b1);
      chk("mid_flush", bus.flush, 1'b1);
      reset = 1'b1;
      #1;
      chk("arst_flush", bus.flush, 1'b0);
      chk("arst_busy", bus.busy, 1'b0);
      chk("arst_hwint", bus.hwint_o, 6'd0);
      chk("arst_take", bus.int_take, 1'b0);
      chk("arst_code", bus.exc_code_o, 5'd0);
      bus.exc_valid = 1'b0;
      bus.hw_irq = '0;
      step();
      reset = 1'b0;
      step();
      chk("arst_idle", bus.busy, 1'b0);
      chk("arst_no_take", bus.int_take, 1'b0);
      chk("sb_drained", sb_q.size(), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
